// File: rtl/picosoc_wb_master.sv
// -----------------------------------------------------------------------------
// picosoc_wb_master
//
// Purpose:
//   Bridges the PicoRV32 native memory bus onto a classic single-cycle
//   Wishbone master. Each CPU request becomes exactly one Wishbone cycle.
//   The cycle ends in one of three ways: on ack, on err, or when a watchdog
//   gives up after TIMEOUT_CYCLES bus cycles with no response. The CPU then
//   gets a one-cycle mem_ready pulse. Error and timeout completions return
//   ERR_DATA and pulse bus_err_o.
//
// Parameters:
//   TIMEOUT_CYCLES  max Wishbone cycles spent waiting for ack/err (>= 1)
//   ERR_DATA        read data returned on error or timeout
//
// Ports:
//   wb_clk_i   in   1   clock, rising edge
//   wb_rst_i   in   1   asynchronous active-low reset
//   mem_valid  in   1   CPU request valid (sampled only while idle)
//   mem_addr   in  32   CPU byte address
//   mem_wdata  in  32   CPU write data
//   mem_wstrb  in   4   CPU byte strobes, 4'b0000 means read
//   mem_ready  out  1   one-cycle completion pulse
//   mem_rdata  out 32   read data, valid while mem_ready is high
//   wbm_adr_o  out 32   Wishbone address
//   wbm_dat_o  out 32   Wishbone write data
//   wbm_dat_i  in  32   Wishbone read data
//   wbm_sel_o  out  4   Wishbone byte selects
//   wbm_we_o   out  1   Wishbone write enable
//   wbm_cyc_o  out  1   Wishbone cycle
//   wbm_stb_o  out  1   Wishbone strobe (always equal to cyc)
//   wbm_ack_i  in   1   Wishbone acknowledge
//   wbm_err_i  in   1   Wishbone error
//   bus_err_o  out  1   one-cycle pulse alongside mem_ready on err/timeout
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module picosoc_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        bus_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // The counter counts completed bus cycles without a response. When the
    // cycle now ending would bring the count to TIMEOUT_CYCLES, the access
    // aborts. The counter therefore stops at TIMEOUT_CYCLES and never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              isWrite;

    assign isWrite = |mem_wstrb;

    // State and output registers. Every output comes straight from one of
    // these flops. Reset clears them without waiting for a clock edge, so
    // reset drops a bus cycle in flight with no completion pulse.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. Address, data, selects and we are latched only when
    // an access starts, so they stay stable for the whole bus cycle. The
    // response checks run in priority order: err beats ack, and either one
    // beats the timeout on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    adr_d   = mem_addr;
                    dat_d   = mem_wdata;
                    we_d    = isWrite;
                    sel_d   = isWrite ? mem_wstrb : 4'hF;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end

            BUS: begin
                if (wbm_err_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rdata_d = wbm_dat_i;
                    end
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign bus_err_o = err_q;

endmodule

// File: doc/picosoc_wb_master.md
PICOSOC_WB_MASTER -- requirements
Module: picosoc_wb_master

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 255: maximum cycles a Wishbone cycle may wait for ack/err before abort.
REQ-002 SHALL provide parameter ERR_DATA, default 32'hFFFF_FFFF: read data returned on error or timeout.
REQ-003 SHALL have ports (clock and reset first):
 wb_clk_i  in  1  single clock; all logic on rising edge
 wb_rst_i  in  1  one clock; reset is asynchronous and active-low
 mem_valid  in  1  CPU native-bus request valid
 mem_addr  in  32  request byte address
 mem_wdata  in  32  write data
 mem_wstrb  in  4  byte write strobes; 4'b0000 = read
 mem_ready  out  1  one-cycle completion pulse
 mem_rdata  out  32  read data, valid while mem_ready=1
 wbm_adr_o  out  32  Wishbone address
 wbm_dat_o  out  32  Wishbone write data
 wbm_dat_i  in  32  Wishbone read data
 wbm_sel_o  out  4  byte selects
 wbm_we_o  out  1  write enable
 wbm_cyc_o  out  1  cycle
 wbm_stb_o  out  1  strobe
 wbm_ack_i  in  1  slave acknowledge
 wbm_err_i  in  1  slave error
 bus_err_o  out  1  one-cycle pulse: transaction ended by err or timeout
REQ-004 All outputs SHALL be registered.

Function
REQ-005 SHALL implement FSM with states IDLE, BUS, DONE.
REQ-006 IDLE: on edge with mem_valid=1 SHALL latch mem_addr->wbm_adr_o, mem_wdata->wbm_dat_o, wbm_we_o=|mem_wstrb, wbm_sel_o=mem_wstrb if write else 4'hF, set wbm_cyc_o=wbm_stb_o=1, clear timeout counter, go BUS.
REQ-007 Single outstanding transaction; no pipelining; mem_* inputs SHALL be ignored outside IDLE.
REQ-008 BUS, wbm_ack_i=1 and wbm_err_i=0: SHALL deassert cyc/stb/we on that edge, load mem_rdata=wbm_dat_i for reads (hold previous value for writes), go DONE.
REQ-009 BUS, wbm_err_i=1 (regardless of ack): SHALL deassert cyc/stb/we, load mem_rdata=ERR_DATA, set bus_err_o=1, go DONE.
REQ-010 BUS, no ack/err: timeout counter SHALL increment each cycle; when it equals TIMEOUT_CYCLES, SHALL abort identically to REQ-009; ack or err on that same edge takes priority over timeout.
REQ-011 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); it SHALL never wrap.
REQ-012 DONE: mem_ready=1 and bus_err_o as set for exactly one cycle, then both clear and FSM returns to IDLE unconditionally.
REQ-013 In IDLE, mem_valid held high from the previous transaction SHALL NOT occur per CPU protocol; any mem_valid=1 sampled in IDLE starts a new transaction (back-to-back allowed, min 3 cycles per access).
REQ-014 Latency: cyc/stb high 1 cycle after mem_valid sampled; mem_ready high 1 cycle after ack/err sampled; with a slave acking 1 cycle after stb, mem_ready rises 3 edges after mem_valid sampled.
REQ-015 wbm_cyc_o and wbm_stb_o SHALL always be equal; all wbm_* outputs stable throughout BUS.

Reset
REQ-016 wb_rst_i=0 SHALL immediately force: state IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=wbm_dat_o=0, wbm_sel_o=0, mem_ready=0, mem_rdata=0, bus_err_o=0, counter=0.
REQ-017 Reset mid-transaction SHALL abort with no mem_ready pulse; first request after reset release SHALL be handled normally.

Verification
REQ-018 Read: mem_valid, addr 0x0000_0010, wstrb 0; slave acks 1 cycle after stb with 0xDEAD_BEEF -> sel=4'hF, we=0, mem_ready one cycle, mem_rdata=0xDEAD_BEEF, bus_err_o=0.
REQ-019 Byte write: addr 0x0000_0004, wdata 0x1122_3344, wstrb 4'b0010 -> wbm_sel_o=4'b0010, we=1, dat_o=0x1122_3344 stable until ack; mem_ready one cycle.
REQ-020 Error: slave asserts ack and err together on a read -> mem_rdata=ERR_DATA, bus_err_o and mem_ready pulse together for one cycle.
REQ-021 Timeout: TIMEOUT_CYCLES=8, slave never responds -> cyc drops after 8 BUS cycles, mem_ready+bus_err_o pulse, mem_rdata=0xFFFF_FFFF; ack on the 8th cycle -> normal completion, no bus_err_o.
REQ-022 Reset: assert wb_rst_i=0 while in BUS -> cyc/stb low without a clock edge, no mem_ready; after release, a read completes per REQ-018.
REQ-023 Back-to-back: two reads issued with mem_valid re-asserted the cycle after mem_ready -> two distinct Wishbone cycles, each with its own mem_ready pulse and correct data.
